// File: rtl/reg_file_dbg_pkg.sv
// Shared types and constants for the register-file debug initiator.
// Imported by the RTL and the testbench so both use one set of op encodings.
package reg_file_dbg_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] LAST_REG = '1;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    CLR,
    RSP
  } state_e;

endpackage

// File: rtl/reg_file_dbg_master.sv
// Debug-side initiator for the RV32I register file: runs READ / WRITE / DUMP / CLEAR
// commands on the register-file ports and returns results over a valid/ready channel.
module reg_file_dbg_master
  import reg_file_dbg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [XLEN-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [AW-1:0]   rsp_addr,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_last,
  output logic [AW-1:0]   rf_rs1,
  input  logic [XLEN-1:0] rf_rs1_v,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_rd_v,
  output logic            rf_we,
  output logic            busy
);

  state_e          state_q, state_d;
  cmd_op_e         op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_last_q, rsp_last_d;
  logic            we_int;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no branch can leave
    // one unassigned and infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    we_int     = 1'b0;
    rf_rs1     = '0;
    rf_rd      = '0;
    rf_rd_v    = '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op_e'(cmd_op);
          data_d = cmd_data;
          unique case (cmd_op_e'(cmd_op))
            OP_READ:  begin addr_d = cmd_addr;  state_d = RD;  end
            OP_WRITE: begin addr_d = cmd_addr;  state_d = WR;  end
            OP_DUMP:  begin addr_d = '0;        state_d = RD;  end
            OP_CLEAR: begin addr_d = AW'(1);    state_d = CLR; end
            default:  state_d = IDLE;
          endcase
        end
      end

      RD: begin
        rf_rs1     = addr_q;
        rsp_addr_d = addr_q;
        rsp_data_d = rf_rs1_v;
        rsp_last_d = (op_q != OP_DUMP) || (addr_q == LAST_REG);
        state_d    = RSP;
      end

      WR: begin
        rf_rd      = addr_q;
        rf_rd_v    = data_q;
        we_int     = (addr_q != '0);
        rsp_addr_d = addr_q;
        rsp_data_d = (addr_q == '0) ? '0 : data_q;
        rsp_last_d = 1'b1;
        state_d    = RSP;
      end

      CLR: begin
        rf_rd   = addr_q;
        we_int  = 1'b1;
        if (addr_q == LAST_REG) begin
          rsp_addr_d = LAST_REG;
          rsp_data_d = '0;
          rsp_last_d = 1'b1;
          state_d    = RSP;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end

      RSP: begin
        // Beat registers are not touched here, so a stalled beat holds steady.
        if (rsp_ready) begin
          if ((op_q == OP_DUMP) && (addr_q != LAST_REG)) begin
            addr_d  = addr_q + AW'(1);
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
    end
  end

  // Handshakes and write strobes are masked during reset so an abandoned command
  // cannot complete a beat or write on the reset edge.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RSP) && !rst;
  assign rf_we     = we_int && !rst;
  assign busy      = (state_q != IDLE);
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_reg_file_dbg_master.sv
// Randomised bench for reg_file_dbg_master: command-level reference model, a simple
// register-file model on the rf_* ports, and a monitor that scores every beat and write.
module tb_reg_file_dbg_master;
  import reg_file_dbg_pkg::*;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            last;
  } beat_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    int              cyc;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [XLEN-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [AW-1:0]   rsp_addr;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_last;
  logic [AW-1:0]   rf_rs1;
  logic [XLEN-1:0] rf_rs1_v;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_rd_v;
  logic            rf_we;
  logic            busy;

  always #5 clk = ~clk;

  reg_file_dbg_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rf_rs1    (rf_rs1),
    .rf_rs1_v  (rf_rs1_v),
    .rf_rd     (rf_rd),
    .rf_rd_v   (rf_rd_v),
    .rf_we     (rf_we),
    .busy      (busy)
  );

  // Register file seen by the DUT: x0 always reads zero.
  logic [XLEN-1:0] rf_mem [32];
  always @(posedge clk) if (rf_we) rf_mem[rf_rd] <= rf_rd_v;
  assign rf_rs1_v = (rf_rs1 == '0) ? '0 : rf_mem[rf_rs1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_done = 0;
  int ready_mode = 1;  // 0 = stall, 1 = always ready, 2 = random

  logic [XLEN-1:0] exp_rf [32];
  beat_t beat_q [$];
  wr_t   we_q [$];
  logic  lat_pending = 1'b0;
  int    lat_exp = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Command-level reference: what each accepted command must produce.
  task automatic model_accept(input cmd_op_e op, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    lat_pending = 1'b1;
    lat_exp     = cyc + 2;
    exp_rf[0]   = '0;
    case (op)
      OP_READ:  beat_q.push_back('{a, exp_rf[a], 1'b1});
      OP_WRITE: begin
        if (a != 0) begin
          exp_rf[a] = d;
          we_q.push_back('{a, d, cyc + 1});
        end
        beat_q.push_back('{a, (a == 0) ? '0 : d, 1'b1});
      end
      OP_DUMP:  for (int i = 0; i < 32; i++) beat_q.push_back('{AW'(i), exp_rf[i], i == 31});
      OP_CLEAR: begin
        for (int i = 1; i < 32; i++) begin
          exp_rf[i] = '0;
          we_q.push_back('{AW'(i), '0, cyc + i});
        end
        beat_q.push_back('{AW'(31), '0, 1'b1});
        lat_exp = cyc + 32;
      end
      default: ;
    endcase
  endtask

  // Monitor: samples 2 time units after the falling edge, well away from posedge.
  initial begin
    beat_t b;
    beat_t st_beat;
    wr_t   w;
    logic  prev_stall;
    prev_stall = 1'b0;
    st_beat    = '{'0, '0, 1'b0};
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        beat_q.delete();
        we_q.delete();
        lat_pending = 1'b0;
        prev_stall  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", rsp_valid, 1'b1);
          check("stall_addr", rsp_addr, st_beat.addr);
          check("stall_data", rsp_data, st_beat.data);
          check("stall_last", rsp_last, st_beat.last);
        end
        prev_stall = rsp_valid && !rsp_ready;
        st_beat    = '{rsp_addr, rsp_data, rsp_last};

        if (!busy) begin
          check("idle_rf_ports", rf_we | (|rf_rs1) | (|rf_rd) | (|rf_rd_v), 1'b0);
          check("idle_cmd_ready", cmd_ready, 1'b1);
        end else begin
          check("busy_cmd_ready", cmd_ready, 1'b0);
        end

        if (lat_pending && rsp_valid) begin
          check("first_beat_cycle", cyc, lat_exp);
          lat_pending = 1'b0;
        end

        if (rf_we) begin
          if (we_q.size() == 0) check("we_unexpected", rf_we, 1'b0);
          else begin
            w = we_q.pop_front();
            check($sformatf("we_addr[x%0d]", w.addr), rf_rd, w.addr);
            check($sformatf("we_data[x%0d]", w.addr), rf_rd_v, w.data);
            check($sformatf("we_cycle[x%0d]", w.addr), cyc, w.cyc);
          end
        end else if (we_q.size() != 0 && we_q[0].cyc <= cyc) begin
          check($sformatf("we_missing[x%0d]", we_q[0].addr), rf_we, 1'b1);
          void'(we_q.pop_front());
        end

        if (rsp_valid && rsp_ready) begin
          if (beat_q.size() == 0) check("rsp_unexpected", rsp_valid, 1'b0);
          else begin
            b = beat_q.pop_front();
            check($sformatf("rsp_addr[x%0d]", b.addr), rsp_addr, b.addr);
            check($sformatf("rsp_data[x%0d]", b.addr), rsp_data, b.data);
            check($sformatf("rsp_last[x%0d]", b.addr), rsp_last, b.last);
          end
          if (rsp_last) n_done++;
        end

        if (cmd_valid && cmd_ready) begin
          n_acc++;
          model_accept(cmd_op_e'(cmd_op), cmd_addr, cmd_data);
        end
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input cmd_op_e op, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    #3;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("cmd_accepted", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while ((busy || beat_q.size() != 0 || we_q.size() != 0) && n < budget);
    check("cmd_completed", busy || beat_q.size() != 0 || we_q.size() != 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int done0;
    int n;
    int r;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_READ;
    cmd_addr  = '0;
    cmd_data  = '0;
    for (int i = 0; i < 32; i++) exp_rf[i] = '0;

    repeat (3) @(negedge clk);
    #3;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_addr", rsp_addr, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_last", rsp_last, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_rs1", rf_rs1, '0);
    check("rst_rf_rd", rf_rd, '0);
    check("rst_rf_rd_v", rf_rd_v, '0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    ready_mode = 1;
    send(OP_WRITE, 5, 32'hDEAD_BEEF); wait_done(100);
    send(OP_READ, 5, '0);             wait_done(100);
    send(OP_WRITE, 0, 32'h1234);      wait_done(100);
    send(OP_READ, 0, '0);             wait_done(100);

    ready_mode = 2;
    for (int i = 1; i < 32; i++) begin
      send(OP_WRITE, AW'(i), 32'h100 + i);
      wait_done(200);
    end
    send(OP_DUMP, AW'($urandom_range(0, 31)), '0);
    wait_done(2000);

    send(OP_CLEAR, AW'($urandom_range(0, 31)), 32'hFFFF_FFFF);
    wait_done(2000);
    send(OP_DUMP, '0, '0);
    wait_done(2000);

    // Indefinite stall on a single beat.
    for (int i = 1; i < 32; i++) begin
      send(OP_WRITE, AW'(i), $urandom);
      wait_done(200);
    end
    ready_mode = 0;
    send(OP_READ, 7, '0);
    repeat (20) @(negedge clk);
    #3;
    check("stalled_rsp_valid", rsp_valid, 1'b1);
    ready_mode = 1;
    wait_done(100);

    // Reset in the middle of a DUMP.
    ready_mode = 2;
    send(OP_DUMP, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!(rsp_valid && rsp_addr == 10) && n < 1000);
    check("dump_reached_beat10", rsp_valid && rsp_addr == 10, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #3;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("midrst_after_cmd_ready", cmd_ready, 1'b1);
    check("midrst_pending_beats", beat_q.size(), 0);
    send(OP_READ, 3, '0);
    wait_done(200);

    // cmd_valid held high with alternating ops: one acceptance per 3 cycles.
    ready_mode = 1;
    acc0  = n_acc;
    done0 = n_done;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = (i % 2 == 1) ? OP_WRITE : OP_READ;
      cmd_addr  = AW'($urandom_range(0, 31));
      cmd_data  = $urandom;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(200);
    check("hold_accept_count", n_acc - acc0, 20);
    check("hold_done_count", n_done - done0, n_acc - acc0);

    // Random command mix with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 19);
      if (r < 9)       send(OP_READ, AW'($urandom_range(0, 31)), $urandom);
      else if (r < 17) send(OP_WRITE, AW'($urandom_range(0, 31)), $urandom);
      else if (r < 19) send(OP_DUMP, AW'($urandom_range(0, 31)), $urandom);
      else             send(OP_CLEAR, AW'($urandom_range(0, 31)), $urandom);
      wait_done(2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_dbg_master.md
# reg_file_dbg_master

Debug-side initiator for the RV32I register file. It accepts single read, write, dump-all and clear-all commands from a debug host over a valid/ready command channel, and drives the register-file ports (one read port, the write port) to carry them out. Results return over a valid/ready response channel. It sits between the debug transport and the register-file port mux, which selects this block while the core is halted.

## Interface
- XLEN, 32, register width
- AW, 5, register address width (32 registers, x0 hard-wired zero)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  command: 00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
- cmd_addr  in  AW  register index (READ/WRITE only)
- cmd_data  in  XLEN  write data (WRITE only)
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  host accepts beat
- rsp_addr  out  AW  register index of beat
- rsp_data  out  XLEN  register value / write echo
- rsp_last  out  1  final beat of the command
- rf_rs1  out  AW  register-file read address
- rf_rs1_v  in  XLEN  register-file read data (combinational from rf_rs1)
- rf_rd  out  AW  register-file write address
- rf_rd_v  out  XLEN  register-file write data
- rf_we  out  1  register-file write enable
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD, WR, CLR, RSP.
- IDLE: cmd_ready=1. On handshake, latch op, addr and data. READ/DUMP→RD (DUMP starts at addr 0). WRITE→WR. CLEAR→CLR with addr 1.
- RD: rf_rs1=addr. At end of cycle, rsp_data←rf_rs1_v and rsp_addr←addr. Then →RSP.
- WR: one cycle. rf_rd=addr, rf_rd_v=data, rf_we=(addr!=0). rsp_data←(addr==0 ? 0 : data), rsp_addr←addr. Then →RSP.
- CLR: rf_we=1, rf_rd=addr, rf_rd_v=0, addr increments each cycle for x1..x31 (31 cycles). After x31: rsp_addr←31, rsp_data←0, →RSP.
- RSP: rsp_valid=1. rsp_addr, rsp_data and rsp_last are held stable until rsp_ready.
  - On handshake, DUMP with addr<31 → addr+1, →RD.
  - Otherwise →IDLE.
- rsp_last=1 for READ, WRITE and CLEAR beats. For DUMP, rsp_last=1 only on the addr 31 beat.
- rf_we is 0 in every state except WR (addr≠0) and CLR. rf_rs1, rf_rd and rf_rd_v are don't-care when unused but must be 0 in IDLE.
- Commands are never queued. cmd_valid outside IDLE is ignored (cmd_ready=0).

## Timing
- Reset (rst high at an edge): state←IDLE. rsp_valid, rsp_addr, rsp_data, rsp_last, rf_we, rf_rs1, rf_rd, rf_rd_v and busy are all 0. cmd_ready is 0 while rst is high and 1 in the first cycle after deassertion.
- Reset mid-operation: the in-flight command is abandoned. No further rf_we pulses or response beats occur. A partial CLEAR leaves already-cleared registers cleared.
- READ latency: handshake at cycle T, rf_rs1 driven in T+1, rsp_valid in T+2.
- WRITE: rf_we high for exactly cycle T+1, rsp_valid in T+2. A READ accepted after the write response returns the new value.
- DUMP: 32 beats, addresses 0..31 in order. Each beat takes at least 2 cycles (RD, RSP), so the minimum is 64 cycles from handshake to the last beat. The minimum back-to-back command issue rate is one command per 3 cycles.
- CLEAR: rf_we high in T+1..T+31, response in T+32.
- rsp_ready held low: the beat is stalled indefinitely with no changes to any outputs.

## Structure
- Shared package reg_file_dbg_pkg: XLEN, AW, cmd_op encodings (OP_READ, OP_WRITE, OP_DUMP, OP_CLEAR), state enum.
- No sub-module: a single FSM with address counter and response register, about 150–250 lines.

## Test plan
- WRITE x5=0xDEADBEEF → rf_we is 1 for one cycle with rf_rd=5 and rf_rd_v=0xDEADBEEF. Response addr 5, data 0xDEADBEEF, last 1. Then READ x5 → rsp_valid 2 cycles after handshake with data 0xDEADBEEF.
- WRITE x0=0x1234 → rf_we stays 0, response data 0. READ x0 → data 0.
- Preload xN=0x100+N, then DUMP with rsp_ready toggling randomly → 32 beats with addr N and data 0x100+N (x0=0). Outputs stay stable during stalls. rsp_last is set only on addr 31.
- CLEAR → 31 rf_we pulses for addr 1..31 with data 0, then one response (addr 31, data 0, last 1). A following DUMP returns all zeros.
- Assert rst during beat 10 of a DUMP → rsp_valid=0 and busy=0 on the next cycle. cmd_ready rises after deassertion. A fresh READ x3 then completes normally.
- Hold cmd_valid high with alternating ops while busy → only one command is accepted per return to IDLE, and no command is lost or duplicated.
